component_bit_packer: RTL
=========================

COMPONENT_BIT_PACKER -- requirements
Module: component_bit_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port sb_enable  in  1  code valid this cycle.
REQ-005 SHALL have port sb_val  in  64  code value, right-justified; bits at and above sb_size_of_bit ignored.
REQ-006 SHALL have port sb_size_of_bit  in  64  code length in bits, legal range 0..32.
REQ-007 SHALL have port sb_flush  in  1  end of component; pad and emit residual bits.
REQ-008 SHALL have port out_ready  in  1  downstream accepts head word.
REQ-009 SHALL have port out_valid  out  1  head word valid.
REQ-010 SHALL have port out_data  out  32  packed word, MSB = earliest bit.
REQ-011 SHALL have port out_bytes  out  3  valid bytes in out_data (1..4), left-justified.
REQ-012 SHALL have port busy  out  1  high while in DRAIN.
REQ-013 SHALL have port flush_done  out  1  one-cycle pulse when flush residue is queued.
REQ-014 SHALL have port total_bytes  out  32  bytes queued since reset or previous flush_done.
REQ-015 SHALL have port overflow  out  1  sticky; a word was dropped because the FIFO was full.
REQ-016 SHALL have port size_err  out  1  sticky; sb_size_of_bit > 32 received.

Function
REQ-017 SHALL keep a 64-bit accumulator acc and a bit count cnt; invariant cnt < 32 after every edge.
REQ-018 SHALL, on sb_enable with size <= 32, append the low size bits of sb_val MSB-first after the existing cnt bits.
REQ-019 SHALL, in the same edge, push acc[63:32] with out_bytes=4 when cnt+size >= 32, shift acc left 32, and set cnt = cnt+size-32.
REQ-020 SHALL treat size 0 as a no-op, with no push and no error.
REQ-021 SHALL, when size > 32, set size_err, drop the code, and leave acc and cnt unchanged.
REQ-022 SHALL implement FSM states RUN and DRAIN; the reset state is RUN.
REQ-023 SHALL, in RUN on sb_flush, first apply any same-cycle sb_enable code, then go to DRAIN.
REQ-024 SHALL, in DRAIN with cnt > 0, push acc[63:32] with low bits zero-padded and out_bytes = ceil(cnt/8); it SHALL then clear cnt, pulse flush_done, and return to RUN.
REQ-025 SHALL, in DRAIN with cnt = 0, push nothing, pulse flush_done, and return to RUN.
REQ-026 SHALL stall in DRAIN while the FIFO is full; busy stays high and nothing is lost.
REQ-027 SHALL, on sb_enable or sb_flush while in DRAIN, drop the input and set overflow.
REQ-028 SHALL, in RUN on a required push with the FIFO full, drop the word and set overflow; acc and cnt still advance.
REQ-029 SHALL add out_bytes of each pushed word to total_bytes.
REQ-030 SHALL hold total_bytes while flush_done is high and clear it on the following edge.
REQ-031 SHALL present FIFO output first-word-fall-through: a word pushed at edge N shows out_valid high after edge N.
REQ-032 SHALL pop the head when out_valid and out_ready are both high; push and pop in the same edge on a full FIFO SHALL succeed.
REQ-033 SHALL hold out_data and out_bytes stable while out_valid is high and out_ready is low.

Reset
REQ-034 SHALL, while reset is high, clear acc, cnt, FIFO, total_bytes, overflow, and size_err, and set state RUN.
REQ-035 SHALL, while reset is high, drive out_valid, busy, and flush_done to 0, and out_data and out_bytes to 0.
REQ-036 SHALL, on reset asserted mid-DRAIN, discard residual bits and raise no flush_done.

Verification
REQ-037 SHALL verify: reset held 2 cycles with random inputs -> all outputs 0 and FIFO empty afterwards.
REQ-038 SHALL verify: 4x {val=0xFF,size=8}, out_ready=1 -> one word 0xFFFFFFFF, out_bytes=4, valid after the 4th edge.
REQ-039 SHALL verify: {val=0xFFFF,size=4} then flush -> word 0xF0000000, out_bytes=1, flush_done, total_bytes=1.
REQ-040 SHALL verify: 2x {val=0x1FFFF,size=17} then flush -> 0xFFFFFFFF/4, then 0xC0000000/1; total_bytes=5.
REQ-041 SHALL verify: out_ready=0, 5 full words -> 4 queued, overflow=1; then out_ready=1 drains 4 words in order.
REQ-042 SHALL verify: {size=40} -> size_err=1, cnt unchanged; a following {val=0x5,size=3}+flush -> 0xA0000000/1.

Source files
------------

// File: rtl/component_bit_packer.sv
// component_bit_packer
//   Packs variable-length codes (0..32 bits, MSB-first) into 32-bit words
//   and queues them in a small first-word-fall-through FIFO. A flush pads the
//   residual bits of a component with zeros and emits them as a partial word.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   sb_enable           : code valid this cycle
//   sb_val[63:0]        : code value, right-justified
//   sb_size_of_bit[63:0]: code length in bits (legal 0..32)
//   sb_flush            : end of component, emit residual bits
//   out_ready           : downstream accepts the head word
//   out_valid           : head word valid
//   out_data[31:0]      : packed word, MSB = earliest bit
//   out_bytes[2:0]      : valid bytes in out_data (1..4), left-justified
//   busy                : high while draining the residual
//   flush_done          : one-cycle pulse once the flush residue is queued
//   total_bytes[31:0]   : bytes queued since reset or the previous flush_done
//   overflow            : sticky, a word or input was dropped
//   size_err            : sticky, a code longer than 32 bits was received
module component_bit_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sb_enable,
  input  logic [63:0] sb_val,
  input  logic [63:0] sb_size_of_bit,
  input  logic        sb_flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        busy,
  output logic        flush_done,
  output logic [31:0] total_bytes,
  output logic        overflow,
  output logic        size_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [63:0]   acc_q, acc_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   total_q, total_d;
  logic          ovf_q, ovf_d;
  logic          serr_q, serr_d;
  logic          fdone_q, fdone_d;
  logic [AW:0]   wr_q, rd_q;
  logic [34:0]   mem_q [FIFO_DEPTH];

  logic [AW:0]   fcount;
  logic          empty, full, pop, can_push;
  logic          push;
  logic [31:0]   push_data;
  logic [2:0]    push_bytes;
  logic          size_ok;
  logic [5:0]    size6;
  logic [63:0]   code;
  logic [6:0]    sum;
  logic [63:0]   merged;
  logic [34:0]   head;

  // FIFO status; a pop on the same edge frees the slot a full FIFO needs.
  always_comb begin
    fcount   = wr_q - rd_q;
    empty    = (fcount == '0);
    full     = (fcount == (AW+1)'(FIFO_DEPTH));
    pop      = !empty && out_ready;
    can_push = !full || pop;
  end

  // Code alignment: live bits occupy acc[63 -: cnt]; the new code lands just below.
  always_comb begin
    size_ok = (sb_size_of_bit <= 64'd32);
    size6   = sb_size_of_bit[5:0];
    code    = sb_val & ~({64{1'b1}} << size6);
    sum     = {1'b0, cnt_q} + {1'b0, size6};
    merged  = acc_q | (code << (7'd64 - sum));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    serr_d     = serr_q;
    fdone_d    = 1'b0;
    total_d    = fdone_q ? 32'd0 : total_q;
    push       = 1'b0;
    push_data  = 32'd0;
    push_bytes = 3'd0;
    case (state_q)
      RUN: begin
        if (sb_enable) begin
          if (!size_ok) begin
            serr_d = 1'b1;
          end else if (size6 != 6'd0) begin
            if (sum >= 7'd32) begin
              // Accumulator advances even when the word cannot be queued.
              if (can_push) begin
                push       = 1'b1;
                push_data  = merged[63:32];
                push_bytes = 3'd4;
              end else begin
                ovf_d = 1'b1;
              end
              acc_d = merged << 32;
              cnt_d = 6'(sum - 7'd32);
            end else begin
              acc_d = merged;
              cnt_d = sum[5:0];
            end
          end
        end
        if (sb_flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (sb_enable || sb_flush) ovf_d = 1'b1;
        if (cnt_q == 6'd0) begin
          fdone_d = 1'b1;
          state_d = RUN;
        end else if (can_push) begin
          // Bits below cnt are already zero, so acc[63:32] is the padded residue.
          push       = 1'b1;
          push_data  = acc_q[63:32];
          push_bytes = 3'(({1'b0, cnt_q} + 7'd7) >> 3);
          acc_d      = 64'd0;
          cnt_d      = 6'd0;
          fdone_d    = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (push) total_d = total_d + 32'(push_bytes);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= 64'd0;
      cnt_q   <= 6'd0;
      total_q <= 32'd0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      fdone_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      fdone_q <= fdone_d;
      wr_q    <= wr_q + {{AW{1'b0}}, push};
      rd_q    <= rd_q + {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_q[AW-1:0]] <= {push_bytes, push_data};
  end

  // Outputs, forced to zero while reset is held
  always_comb begin
    head        = mem_q[rd_q[AW-1:0]];
    out_valid   = !reset && !empty;
    out_data    = out_valid ? head[31:0]  : 32'd0;
    out_bytes   = out_valid ? head[34:32] : 3'd0;
    busy        = !reset && (state_q == DRAIN);
    flush_done  = !reset && fdone_q;
    total_bytes = reset ? 32'd0 : total_q;
    overflow    = !reset && ovf_q;
    size_err    = !reset && serr_q;
  end

endmodule
